// File: rtl/l2_lookup_pipe_pkg.sv
// rtl/l2_lookup_pipe_pkg.sv - lookup-mode constants and response record for the L2 lookup stage
package l2_lookup_pipe_pkg;

    localparam logic [1:0] L2_LOOKUP     = 2'd0;
    localparam logic [1:0] L2_LOOKUP_FWD = 2'd1;
    localparam logic [1:0] L2_EVICT_SET  = 2'd2;

    // Way fields are sized for up to 256 ways; instances use the low WAY_BITS.
    localparam int L2_WAY_W = 8;

    typedef struct packed {
        logic                tag_hit;
        logic [L2_WAY_W-1:0] way_hit;
        logic                multi_hit;
        logic                empty_found;
        logic [L2_WAY_W-1:0] empty_way;
        logic [L2_WAY_W-1:0] evict_way;
    } l2_lookup_rsp_t;

endpackage

// File: rtl/l2_way_match.sv
// rtl/l2_way_match.sv - combinational tag compare, empty detect and lowest-index encoders
module l2_way_match #(
    parameter int WAYS       = 8,
    parameter int TAG_BITS   = 20,
    parameter int STATE_BITS = 3,
    parameter int INVALID    = 0,
    localparam int WB        = $clog2(WAYS)
) (
    input  logic [TAG_BITS-1:0]        i_tag,
    input  logic [WAYS*TAG_BITS-1:0]   i_tags,
    input  logic [WAYS*STATE_BITS-1:0] i_states,
    output logic [WAYS-1:0]            o_match,
    output logic [WAYS-1:0]            o_empty,
    output logic                       o_hit,
    output logic [WB-1:0]              o_hit_way,
    output logic                       o_empty_found,
    output logic [WB-1:0]              o_empty_way,
    output logic                       o_multi
);

    always_comb begin
        o_match = '0;
        o_empty = '0;
        for (int i = 0; i < WAYS; i++) begin
            o_empty[i] = (i_states[i*STATE_BITS +: STATE_BITS] == STATE_BITS'(INVALID));
            o_match[i] = !o_empty[i] && (i_tags[i*TAG_BITS +: TAG_BITS] == i_tag);
        end
    end

    // Scan downward so the lowest set index is the last assignment.
    always_comb begin
        o_hit_way   = '0;
        o_empty_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (o_match[i]) o_hit_way = WB'(i);
            if (o_empty[i]) o_empty_way = WB'(i);
        end
    end

    assign o_hit         = |o_match;
    assign o_empty_found = |o_empty;
    assign o_multi       = |(o_match & (o_match - WAYS'(1)));

endmodule

// File: rtl/l2_lookup_pipe.sv
// rtl/l2_lookup_pipe.sv - handshaked L2 tag lookup with registered result and round-robin victim pointer
module l2_lookup_pipe
    import l2_lookup_pipe_pkg::*;
#(
    parameter int WAYS       = 8,
    parameter int TAG_BITS   = 20,
    parameter int STATE_BITS = 3,
    parameter int INVALID    = 0,
    localparam int WAY_BITS  = $clog2(WAYS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_mode,
    input  logic [TAG_BITS-1:0]        req_tag,
    input  logic [WAYS*TAG_BITS-1:0]   req_tags,
    input  logic [WAYS*STATE_BITS-1:0] req_states,
    input  logic [WAY_BITS-1:0]        req_way,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_tag_hit,
    output logic [WAY_BITS-1:0]        rsp_way_hit,
    output logic                       rsp_multi_hit,
    output logic                       rsp_empty_found,
    output logic [WAY_BITS-1:0]        rsp_empty_way,
    output logic [WAY_BITS-1:0]        rsp_evict_way,
    output logic [WAY_BITS-1:0]        evict_ptr
);

    logic [WAYS-1:0]     w_match;
    logic [WAYS-1:0]     w_empty;
    logic                w_hit;
    logic [WAY_BITS-1:0] w_hit_way;
    logic                w_empty_found;
    logic [WAY_BITS-1:0] w_empty_way;
    logic                w_multi;
    logic                w_accept;
    logic                w_unused;
    l2_lookup_rsp_t      w_next;
    l2_lookup_rsp_t      r_rsp;
    logic                r_rsp_valid;
    logic [WAY_BITS-1:0] r_evict_ptr;

    l2_way_match #(
        .WAYS       (WAYS),
        .TAG_BITS   (TAG_BITS),
        .STATE_BITS (STATE_BITS),
        .INVALID    (INVALID)
    ) u_match (
        .i_tag         (req_tag),
        .i_tags        (req_tags),
        .i_states      (req_states),
        .o_match       (w_match),
        .o_empty       (w_empty),
        .o_hit         (w_hit),
        .o_hit_way     (w_hit_way),
        .o_empty_found (w_empty_found),
        .o_empty_way   (w_empty_way),
        .o_multi       (w_multi)
    );

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    // Mode 3 is reserved and falls into the LOOKUP_FWD branch.
    always_comb begin
        w_next = '0;
        case (req_mode)
            L2_EVICT_SET: begin
                w_next.evict_way = L2_WAY_W'(req_way);
            end
            L2_LOOKUP: begin
                w_next.tag_hit     = w_hit;
                w_next.way_hit     = L2_WAY_W'(w_hit_way);
                w_next.multi_hit   = w_multi;
                w_next.empty_found = w_empty_found;
                w_next.empty_way   = L2_WAY_W'(w_empty_way);
                w_next.evict_way   = w_empty_found ? L2_WAY_W'(w_empty_way) : L2_WAY_W'(r_evict_ptr);
            end
            default: begin
                w_next.tag_hit   = w_hit;
                w_next.way_hit   = L2_WAY_W'(w_hit_way);
                w_next.multi_hit = w_multi;
                w_next.evict_way = L2_WAY_W'(r_evict_ptr);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_evict_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp       <= w_next;
                if (req_mode == L2_EVICT_SET)
                    r_evict_ptr <= req_way;
                else if (req_mode == L2_LOOKUP && !w_hit && !w_empty_found)
                    r_evict_ptr <= r_evict_ptr + WAY_BITS'(1);
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid       = r_rsp_valid;
    assign rsp_tag_hit     = r_rsp.tag_hit;
    assign rsp_way_hit     = r_rsp.way_hit[WAY_BITS-1:0];
    assign rsp_multi_hit   = r_rsp.multi_hit;
    assign rsp_empty_found = r_rsp.empty_found;
    assign rsp_empty_way   = r_rsp.empty_way[WAY_BITS-1:0];
    assign rsp_evict_way   = r_rsp.evict_way[WAY_BITS-1:0];
    assign evict_ptr       = r_evict_ptr;

    assign w_unused = ^{w_match, w_empty, r_rsp.way_hit, r_rsp.empty_way, r_rsp.evict_way};

endmodule

// File: tb/tb_l2_lookup_pipe.sv
// tb/tb_l2_lookup_pipe.sv - scoreboard bench for l2_lookup_pipe with directed vectors
module tb_l2_lookup_pipe;
    import l2_lookup_pipe_pkg::*;

    typedef struct packed {
        logic       hit;
        logic [2:0] way;
        logic       multi;
        logic       empty;
        logic [2:0] eway;
        logic [2:0] evict;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_mode = 2'd0;
    logic [19:0]  req_tag = '0;
    logic [159:0] req_tags = '0;
    logic [23:0]  req_states = '0;
    logic [2:0]   req_way = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_tag_hit;
    logic [2:0]   rsp_way_hit;
    logic         rsp_multi_hit;
    logic         rsp_empty_found;
    logic [2:0]   rsp_empty_way;
    logic [2:0]   rsp_evict_way;
    logic [2:0]   evict_ptr;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [19:0] tg[8];
    logic [2:0]  st[8];

    l2_lookup_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_mode        (req_mode),
        .req_tag         (req_tag),
        .req_tags        (req_tags),
        .req_states      (req_states),
        .req_way         (req_way),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tag_hit     (rsp_tag_hit),
        .rsp_way_hit     (rsp_way_hit),
        .rsp_multi_hit   (rsp_multi_hit),
        .rsp_empty_found (rsp_empty_found),
        .rsp_empty_way   (rsp_empty_way),
        .rsp_evict_way   (rsp_evict_way),
        .evict_ptr       (evict_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic h, input logic [2:0] w, input logic m,
                                input logic e, input logic [2:0] ew, input logic [2:0] ev);
        mk = '{hit: h, way: w, multi: m, empty: e, eway: ew, evict: ev};
    endfunction

    task automatic fill(input logic [19:0] base, input logic [2:0] state);
        for (int i = 0; i < 8; i++) begin
            tg[i] = base + 20'(i);
            st[i] = state;
        end
    endtask

    // Drives one request, pushes its expected result when acceptance is certain.
    task automatic send(input logic [1:0] mode, input logic [19:0] tag, input logic [2:0] way, input exp_t e);
        bit ok = 0;
        req_mode = mode;
        req_tag  = tag;
        req_way  = way;
        for (int i = 0; i < 8; i++) begin
            req_tags[i*20 +: 20]  = tg[i];
            req_states[i*3 +: 3]  = st[i];
        end
        req_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back(e);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got no accept required accept within 50 cycles");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("tag_hit",     32'(rsp_tag_hit),     32'(e.hit));
                chk("way_hit",     32'(rsp_way_hit),     32'(e.way));
                chk("multi_hit",   32'(rsp_multi_hit),   32'(e.multi));
                chk("empty_found", 32'(rsp_empty_found), 32'(e.empty));
                chk("empty_way",   32'(rsp_empty_way),   32'(e.eway));
                chk("evict_way",   32'(rsp_evict_way),   32'(e.evict));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_evict_ptr", 32'(evict_ptr), 32'd0);
        chk("rst_evict_way", 32'(rsp_evict_way), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Hit in way 5: pointer must stay put.
        fill(20'h00100, 3'd1);
        tg[5] = 20'h12345;
        send(L2_LOOKUP, 20'h12345, 3'd0, mk(1, 3'd5, 0, 0, 3'd0, 3'd0));
        @(negedge clk);
        chk("ptr_after_hit", 32'(evict_ptr), 32'd0);
        @(posedge clk);
        #1;

        // Miss with ways 2/6 invalid; way 2 carries the request tag but is invalid.
        fill(20'h00200, 3'd1);
        st[2] = 3'd0;
        st[6] = 3'd0;
        tg[2] = 20'hABCDE;
        send(L2_LOOKUP, 20'hABCDE, 3'd0, mk(0, 3'd0, 0, 1, 3'd2, 3'd2));
        @(negedge clk);
        chk("ptr_after_empty_miss", 32'(evict_ptr), 32'd0);
        @(posedge clk);
        #1;

        // EVICT_SET 7 then two full-set misses back-to-back: victims 7 then 0.
        fill(20'h00300, 3'd1);
        send(L2_EVICT_SET, 20'h0, 3'd7, mk(0, 3'd0, 0, 0, 3'd0, 3'd7));
        send(L2_LOOKUP, 20'hFFFFF, 3'd0, mk(0, 3'd0, 0, 0, 3'd0, 3'd7));
        send(L2_LOOKUP, 20'hFFFFF, 3'd0, mk(0, 3'd0, 0, 0, 3'd0, 3'd0));
        @(negedge clk);
        chk("ptr_after_wrap", 32'(evict_ptr), 32'd1);
        @(posedge clk);
        #1;

        // LOOKUP_FWD multi-hit on ways 1 and 3; invalid way 0 with same tag ignored.
        fill(20'h00400, 3'd1);
        tg[0] = 20'h55555;
        st[0] = 3'd0;
        tg[1] = 20'h55555;
        tg[3] = 20'h55555;
        send(L2_LOOKUP_FWD, 20'h55555, 3'd0, mk(1, 3'd1, 1, 0, 3'd0, 3'd1));
        // Reserved mode behaves as LOOKUP_FWD: no empty report, no pointer move.
        fill(20'h00500, 3'd1);
        st[4] = 3'd0;
        send(2'd3, 20'h77777, 3'd0, mk(0, 3'd0, 0, 0, 3'd0, 3'd1));
        @(negedge clk);
        chk("ptr_after_fwd", 32'(evict_ptr), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: A held for 4 cycles while B waits, then both flow.
        fill(20'h00600, 3'd1);
        rsp_ready = 1'b0;
        send(L2_LOOKUP, 20'h00607, 3'd0, mk(1, 3'd7, 0, 0, 3'd0, 3'd1));
        fork
            send(L2_LOOKUP, 20'hEEEEE, 3'd0, mk(0, 3'd0, 0, 0, 3'd0, 3'd1));
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_req_ready", 32'(req_ready), 32'd0);
                    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("bp_tag_hit",   32'(rsp_tag_hit), 32'd1);
                    chk("bp_way_hit",   32'(rsp_way_hit), 32'd7);
                    chk("bp_evict_way", 32'(rsp_evict_way), 32'd1);
                    chk("bp_evict_ptr", 32'(evict_ptr), 32'd1);
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        @(negedge clk);
        chk("ptr_after_bp", 32'(evict_ptr), 32'd2);
        @(posedge clk);
        #1;

        // Reset mid-stream with a held response and pointer at 4.
        send(L2_EVICT_SET, 20'h0, 3'd4, mk(0, 3'd0, 0, 0, 3'd0, 3'd4));
        @(negedge clk);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        fill(20'h00700, 3'd1);
        send(L2_LOOKUP, 20'h00702, 3'd0, mk(1, 3'd2, 0, 0, 3'd0, 3'd4));
        @(negedge clk);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pre_rst_evict_ptr", 32'(evict_ptr), 32'd4);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_tag_hit",   32'(rsp_tag_hit), 32'd0);
        chk("mid_rst_way_hit",   32'(rsp_way_hit), 32'd0);
        chk("mid_rst_evict_way", 32'(rsp_evict_way), 32'd0);
        chk("mid_rst_evict_ptr", 32'(evict_ptr), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        send(L2_LOOKUP, 20'hEEEEE, 3'd0, mk(0, 3'd0, 0, 0, 3'd0, 3'd0));
        @(negedge clk);
        chk("ptr_after_rst_miss", 32'(evict_ptr), 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
